// File: rtl/seg7_pkg.sv
// Shared definitions for the stopwatch 7-segment display path: digit width,
// segment constants and the scan FSM state encoding.
package seg7_pkg;

    localparam int DIGIT_W = 4;

    // Active-low segment patterns, bit6 = g ... bit0 = a
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg7_rom.sv
// BCD to common-anode 7-segment decoder (active-low, g..a).
// Codes 10..15 are not valid BCD and fall back to the '0' pattern.
module seg7_rom
    import seg7_pkg::*;
(
    input  logic [DIGIT_W-1:0] nibble,
    output logic [6:0]         segment
);

    always_comb begin
        segment = SEG_ZERO;
        case (nibble)
            4'd0:    segment = 7'b1000000;
            4'd1:    segment = 7'b1111001;
            4'd2:    segment = 7'b0100100;
            4'd3:    segment = 7'b0110000;
            4'd4:    segment = 7'b0011001;
            4'd5:    segment = 7'b0010010;
            4'd6:    segment = 7'b0000010;
            4'd7:    segment = 7'b1111000;
            4'd8:    segment = 7'b0000000;
            4'd9:    segment = 7'b0010000;
            default: segment = SEG_ZERO;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display with a
// blanking interval per slot. Optional leading-zero blanking: SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
)
(
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_enable,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] i_digits,
    input  logic [NUM_DIGITS-1:0]         i_dp,
    output logic [6:0]                    o_segment,
    output logic                          o_dp,
    output logic [NUM_DIGITS-1:0]         o_anode,
    output logic                          o_frame_start
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_SNAP = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      cnt, cnt_next;
    logic [IDX_W-1:0]      idx, idx_next;
    scan_state_t           state, state_next;
    logic [DIGIT_W-1:0]    snap_nibble, snap_nibble_next;
    logic                  snap_dp, snap_dp_next;
    logic                  frame_next;

    logic [DIGIT_W-1:0]    sel_nibble;
    logic                  sel_dp;
    logic                  suppress;

    logic [6:0]            rom_segment;
    logic [NUM_DIGITS-1:0] anode_next;
    logic [6:0]            segment_next;
    logic                  dp_next;

    always_comb begin
        sel_nibble = '0;
        sel_dp     = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                sel_nibble = i_digits[k*DIGIT_W +: DIGIT_W];
                sel_dp     = i_dp[k];
            end
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every digit above it are 0 with no dp.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        suppress = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (i_digits[k*DIGIT_W +: DIGIT_W] == '0) && !i_dp[k];
            if ((k != 0) && (idx == IDX_W'(k))) begin
                suppress = zero_run;
            end
        end
    end
`else
    assign suppress = 1'b0;
`endif

    always_comb begin
        cnt_next         = cnt;
        idx_next         = idx;
        state_next       = state;
        snap_nibble_next = snap_nibble;
        snap_dp_next     = snap_dp;
        frame_next       = 1'b0;

        if (!i_enable) begin
            cnt_next   = '0;
            idx_next   = '0;
            state_next = ST_BLANK;
        end else if (cnt == CNT_LAST) begin
            cnt_next   = '0;
            idx_next   = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            state_next = ST_BLANK;
            frame_next = (idx == IDX_LAST);
        end else begin
            cnt_next = cnt + CNT_W'(1);
            if (cnt == CNT_SNAP) begin
                snap_nibble_next = sel_nibble;
                snap_dp_next     = sel_dp;
                if (!suppress) begin
                    state_next = ST_SHOW;
                end
            end
        end
    end

    // Decode the value being loaded into the snapshot so outputs update on the same edge.
    seg7_rom u_rom (
        .nibble  (snap_nibble_next),
        .segment (rom_segment)
    );

    always_comb begin
        anode_next   = '1;
        segment_next = SEG_BLANK;
        dp_next      = 1'b1;
        if (state_next == ST_SHOW) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                anode_next[k] = (idx_next != IDX_W'(k));
            end
            segment_next = rom_segment;
            dp_next      = ~snap_dp_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt           <= '0;
            idx           <= '0;
            state         <= ST_BLANK;
            snap_nibble   <= '0;
            snap_dp       <= 1'b0;
            o_anode       <= '1;
            o_segment     <= SEG_BLANK;
            o_dp          <= 1'b1;
            o_frame_start <= 1'b0;
        end else begin
            cnt           <= cnt_next;
            idx           <= idx_next;
            state         <= state_next;
            snap_nibble   <= snap_nibble_next;
            snap_dp       <= snap_dp_next;
            o_anode       <= anode_next;
            o_segment     <= segment_next;
            o_dp          <= dp_next;
            o_frame_start <= frame_next;
        end
    end

endmodule
